// File: rtl/counter6_if.sv
// rtl/counter6_if.sv - count-enable/direction inputs and count output of counter6
interface counter6_if #(
    parameter int WIDTH = 6
);
    logic             trig;
    logic             ctrl;
    logic [WIDTH-1:0] count;

    // Side that steers the counter and observes its value
    modport master (
        output trig,
        output ctrl,
        input  count
    );

    // Side implemented by the counter itself
    modport slave (
        input  trig,
        input  ctrl,
        output count
    );
endinterface

// File: rtl/counter6.sv
// rtl/counter6.sv - WIDTH-bit up/down counter with enable and asynchronous active-low reset
module counter6 #(
    parameter int WIDTH = 6
) (
    input  logic      clk,
    input  logic      reset,
    counter6_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: step up or down when enabled, otherwise hold; arithmetic wraps naturally
    always_comb begin
        count_d = count_q;
        if (bus.trig) begin
            if (bus.ctrl) begin
                count_d = count_q - ONE;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // The only state in the block; reset clears it immediately, independent of clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;

endmodule

// File: tb/tb_counter6.sv
// tb/tb_counter6.sv - directed self-checking bench for counter6
module tb_counter6;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    counter6_if #(.WIDTH(6)) bus ();

    counter6 #(.WIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (%b) expected %0d", tag, obs, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.trig  = 1'b0;
        bus.ctrl  = 1'b0;

        // reset applied before any clock edge
        #2 reset = 1'b0;
        #1 check_eq("reset_async_initial", bus.count, 6'd0);

        // reset held: count stays 0 even with trig active
        bus.trig = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("reset_hold_trig", bus.count, 6'd0);
        end

        // release with trig=1, ctrl=0; release itself must not change count
        @(negedge clk);
        reset    = 1'b1;
        bus.ctrl = 1'b0;
        #1 check_eq("release_no_change", bus.count, 6'd0);
        for (int i = 1; i <= 30; i++) begin
            tick();
            check_eq($sformatf("up_%0d", i), bus.count, 6'(i));
        end

        // asynchronous reset between edges at count=30
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_eq("async_reset_mid_up", bus.count, 6'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("reset_held_after_up", bus.count, 6'd0);
        end

        // up-count wrap over 65 edges
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 65; i++) begin
            tick();
            if (i == 63) check_eq("wrap_up_63", bus.count, 6'd63);
            if (i == 64) check_eq("wrap_up_64", bus.count, 6'd0);
            if (i == 65) check_eq("wrap_up_65", bus.count, 6'd1);
        end

        // reset then down-count with wrap from 0
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("async_reset_before_down", bus.count, 6'd0);
        @(negedge clk);
        reset    = 1'b1;
        bus.ctrl = 1'b1;
        tick();
        check_eq("down_1", bus.count, 6'd63);
        tick();
        check_eq("down_2", bus.count, 6'd62);
        tick();
        check_eq("down_3", bus.count, 6'd61);
        for (int i = 4; i <= 30; i++) tick();
        check_eq("down_30", bus.count, 6'd34);

        // hold at 34 while ctrl toggles and trig glitches between edges
        @(negedge clk);
        bus.ctrl = 1'b0;
        bus.trig = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("hold_%0d", i), bus.count, 6'd34);
            @(negedge clk);
            bus.ctrl = ~bus.ctrl;
            bus.trig = 1'b1;
            #1 bus.trig = 1'b0;
        end

        // count up from reset to 5, then flip direction between edges
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("async_reset_in_hold", bus.count, 6'd0);
        @(negedge clk);
        reset    = 1'b1;
        bus.ctrl = 1'b0;
        bus.trig = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("switch_start_5", bus.count, 6'd5);
        @(negedge clk);
        bus.ctrl = 1'b1;
        tick();
        check_eq("switch_first_4", bus.count, 6'd4);
        tick();
        check_eq("switch_second_3", bus.count, 6'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
